// File: rtl/bus_monitor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bus_monitor_if
// Description : Observation bundle between the bus controller and the
//               bus_monitor statistics block. "master" drives the observed
//               bus lines and reads the statistics; "slave" is the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_monitor_if #(
    parameter int NUM_MASTERS = 12,
    parameter int CNT_WIDTH   = 8
);
    logic [NUM_MASTERS-1:0] m_reqs;
    logic [NUM_MASTERS-1:0] m_grants;
    logic                   bus_util;
    logic [3:0]             mid_current;
    logic [3:0]             sel;
    logic                   clr;
    logic [CNT_WIDTH-1:0]   util_cnt;
    logic                   window_done;
    logic [CNT_WIDTH-1:0]   grant_cnt;
    logic [CNT_WIDTH-1:0]   wait_max;
    logic [3:0]             owner_id;
    logic                   grant_conflict;

    modport master (
        output m_reqs, m_grants, bus_util, mid_current, sel, clr,
        input  util_cnt, window_done, grant_cnt, wait_max, owner_id, grant_conflict
    );

    modport slave (
        input  m_reqs, m_grants, bus_util, mid_current, sel, clr,
        output util_cnt, window_done, grant_cnt, wait_max, owner_id, grant_conflict
    );
endinterface
`default_nettype wire

// File: rtl/bus_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bus_monitor
// Description : Passive bus observer. Produces windowed bus utilization,
//               per-master grant counts, worst-case request-to-grant wait
//               and a sticky multi-grant flag. All outputs registered and
//               all counters saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_monitor #(
    parameter int NUM_MASTERS = 12,
    parameter int WINDOW_LEN  = 100,
    parameter int CNT_WIDTH   = 8
) (
    input  wire logic      clk,
    input  wire logic      rstn,
    bus_monitor_if.slave   mon
);
    localparam int                   C_WIN_W    = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [C_WIN_W-1:0]   C_WIN_LAST = C_WIN_W'(WINDOW_LEN - 1);
    localparam logic [C_WIN_W-1:0]   C_WIN_ONE  = C_WIN_W'(1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

    // Window / utilization state
    logic [C_WIN_W-1:0]   win_cnt_q,     win_cnt_d;
    logic [CNT_WIDTH-1:0] busy_cnt_q,    busy_cnt_d;
    logic [CNT_WIDTH-1:0] util_cnt_q,    util_cnt_d;
    logic                 window_done_q, window_done_d;

    // Per-master statistics
    logic [NUM_MASTERS-1:0] prev_grants_q;
    logic [CNT_WIDTH-1:0]   grant_cnt_q [NUM_MASTERS];
    logic [CNT_WIDTH-1:0]   grant_cnt_d [NUM_MASTERS];
    logic [CNT_WIDTH-1:0]   wait_cnt_q  [NUM_MASTERS];
    logic [CNT_WIDTH-1:0]   wait_cnt_d  [NUM_MASTERS];
    logic [CNT_WIDTH-1:0]   wait_max_q  [NUM_MASTERS];
    logic [CNT_WIDTH-1:0]   wait_max_d  [NUM_MASTERS];
    logic                   conflict_q,  conflict_d;

    // Display registers
    logic [CNT_WIDTH-1:0] disp_grant_q, disp_grant_d;
    logic [CNT_WIDTH-1:0] disp_wait_q,  disp_wait_d;
    logic [3:0]           owner_q;

    logic [NUM_MASTERS-1:0] w_grant_edge;
    logic                   w_multi_grant;
    logic                   w_sel_valid;
    logic [CNT_WIDTH-1:0]   w_busy_next;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == C_CNT_MAX) ? v : v + C_CNT_ONE;
    endfunction

    assign w_grant_edge  = mon.m_grants & ~prev_grants_q;
    // g & (g-1) clears the lowest set bit; anything left means two or more grants
    assign w_multi_grant = |(mon.m_grants & (mon.m_grants - NUM_MASTERS'(1)));
    assign w_sel_valid   = (int'(mon.sel) < NUM_MASTERS);
    assign w_busy_next   = mon.bus_util ? busy_cnt_q : sat_inc(busy_cnt_q);

    // Next-state for window, per-master statistics and display; clr overrides all events
    always_comb begin
        win_cnt_d     = win_cnt_q;
        busy_cnt_d    = busy_cnt_q;
        util_cnt_d    = util_cnt_q;
        window_done_d = 1'b0;
        grant_cnt_d   = grant_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        wait_max_d    = wait_max_q;
        conflict_d    = conflict_q | w_multi_grant;
        disp_grant_d  = '0;
        disp_wait_d   = '0;

        if (w_sel_valid) begin
            disp_grant_d = grant_cnt_q[mon.sel];
            disp_wait_d  = wait_max_q[mon.sel];
        end

        // Last cycle of the window folds its own busy bit into the result
        if (win_cnt_q == C_WIN_LAST) begin
            util_cnt_d    = w_busy_next;
            busy_cnt_d    = '0;
            win_cnt_d     = '0;
            window_done_d = 1'b1;
        end else begin
            busy_cnt_d    = w_busy_next;
            win_cnt_d     = win_cnt_q + C_WIN_ONE;
        end

        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant_edge[i]) begin
                grant_cnt_d[i] = sat_inc(grant_cnt_q[i]);
                if (wait_cnt_q[i] > wait_max_q[i]) begin
                    wait_max_d[i] = wait_cnt_q[i];
                end
                wait_cnt_d[i] = '0;
            end else if (mon.m_reqs[i] && !mon.m_grants[i]) begin
                wait_cnt_d[i] = sat_inc(wait_cnt_q[i]);
            end else begin
                // Request withdrawn (or grant held): abandon the pending wait
                wait_cnt_d[i] = '0;
            end
        end

        if (mon.clr) begin
            win_cnt_d     = '0;
            busy_cnt_d    = '0;
            util_cnt_d    = '0;
            window_done_d = 1'b0;
            grant_cnt_d   = '{default: '0};
            wait_cnt_d    = '{default: '0};
            wait_max_d    = '{default: '0};
            conflict_d    = 1'b0;
        end
    end

    // State registers; prev_grants and owner track the bus even through clr
    always_ff @(posedge clk) begin
        if (!rstn) begin
            win_cnt_q     <= '0;
            busy_cnt_q    <= '0;
            util_cnt_q    <= '0;
            window_done_q <= 1'b0;
            prev_grants_q <= '0;
            grant_cnt_q   <= '{default: '0};
            wait_cnt_q    <= '{default: '0};
            wait_max_q    <= '{default: '0};
            conflict_q    <= 1'b0;
            disp_grant_q  <= '0;
            disp_wait_q   <= '0;
            owner_q       <= '0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            busy_cnt_q    <= busy_cnt_d;
            util_cnt_q    <= util_cnt_d;
            window_done_q <= window_done_d;
            prev_grants_q <= mon.m_grants;
            grant_cnt_q   <= grant_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            wait_max_q    <= wait_max_d;
            conflict_q    <= conflict_d;
            disp_grant_q  <= disp_grant_d;
            disp_wait_q   <= disp_wait_d;
            owner_q       <= mon.mid_current;
        end
    end

    assign mon.util_cnt       = util_cnt_q;
    assign mon.window_done    = window_done_q;
    assign mon.grant_cnt      = disp_grant_q;
    assign mon.wait_max       = disp_wait_q;
    assign mon.owner_id       = owner_q;
    assign mon.grant_conflict = conflict_q;

endmodule
`default_nettype wire

// File: doc/bus_monitor.md
Name: bus_monitor

Overview:
- Passive observer that sits directly downstream of the bus controller.
- Consumes the master request/grant vectors, the active-low bus-utilizing line and the current-master ID.
- Produces registered statistics for the seven-segment path (via bi2bcd):
  - windowed bus utilization;
  - per-master grant count and worst-case request-to-grant wait;
  - a sticky multi-grant error flag.
- Never drives the bus.

Parameters:
- NUM_MASTERS, 12, width of request/grant vectors.
- WINDOW_LEN, 100, utilization window in clocks; with the default, util_cnt reads directly as a percentage.
- CNT_WIDTH, 8, width of every statistics counter; all counters saturate at 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock (muxed 10MHz/1Hz clock).
- rstn  input  1  synchronous active-low reset (debounced).
- m_reqs  input  NUM_MASTERS  master request lines, bit i = master i.
- m_grants  input  NUM_MASTERS  arbiter grant lines, bit i = master i.
- bus_util  input  1  bus-utilizing line, active low (0 = bus in use).
- mid_current  input  4  ID of master currently owning the bus.
- sel  input  4  master index whose statistics are shown.
- clr  input  1  single-cycle pulse; clears all statistics.
- util_cnt  output  CNT_WIDTH  busy cycles in last completed window.
- window_done  output  1  one-cycle pulse when util_cnt updates.
- grant_cnt  output  CNT_WIDTH  grant count of master sel.
- wait_max  output  CNT_WIDTH  max request-to-grant wait (clocks) of master sel.
- owner_id  output  4  registered copy of mid_current.
- grant_conflict  output  1  sticky: more than one grant bit seen high in one cycle.

Behaviour:
- Reset (rstn=0 at posedge clk): every output and internal counter goes to 0. This includes the window counter, busy counter, prev-grant register, per-master grant/wait/max registers and the conflict flag.
- Reset mid-window discards the partial window; the first window after reset starts at the cycle following reset release.
- Utilization window:
  - win_cnt counts 0..WINDOW_LEN-1 and wraps.
  - busy_cnt increments (saturating) on each cycle with bus_util==0.
  - On the cycle win_cnt==WINDOW_LEN-1:
    - util_cnt <= busy_cnt plus 1 if that cycle is busy (saturated);
    - busy_cnt <= 0;
    - window_done=1 for exactly that following cycle.
  - With WINDOW_LEN=100, a fully busy window gives util_cnt=100.
- Grant edge detect: prev_grants registered each cycle. Grant edge for master i = m_grants[i] & ~prev_grants[i].
- Grant counting: on a grant edge for master i, grant_cnt[i] += 1, saturating at 255 (CNT_WIDTH=8). A grant held for many cycles counts once.
- Wait tracking, per master i:
  - wait_cnt[i] increments (saturating) every cycle with m_reqs[i]=1 and m_grants[i]=0.
  - On a grant edge: wait_max[i] <= max(wait_max[i], wait_cnt[i]), then wait_cnt[i] <= 0.
  - If the request drops without a grant, wait_cnt[i] <= 0 and nothing is recorded.
  - A grant with no preceding request records a wait of 0.
- Conflict: if popcount(m_grants) > 1 in any cycle, grant_conflict <= 1 and stays set until clr or reset. Each simultaneous grant edge is still counted.
- clr:
  - Same effect as reset on statistics: grant counts, wait counters, maxima, busy/window counters, util_cnt and grant_conflict all go to 0.
  - Does not clear prev_grants or owner_id.
  - clr wins over any event in the same cycle; that cycle's grant edge or busy cycle is dropped.
- Display mux:
  - grant_cnt/wait_max registered from the per-master arrays indexed by sel; one-cycle latency after a sel change or a counter update.
  - sel >= NUM_MASTERS outputs 0.
- owner_id: mid_current delayed one clock.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset release, bus_util=1 held for 100 clocks: window_done pulses once at clock 100; util_cnt=0. Hold bus_util=0 for next 100 clocks: util_cnt=100.
- bus_util=0 for 37 of 100 clocks, then rstn=0 at clock 150 of the run: util_cnt=37 after the first window; all outputs 0 the cycle after reset.
- m_reqs[3]=1 for 5 clocks then m_grants[3]=1 held 20 clocks, repeated 3 times with waits 5, 9, 2; sel=3: grant_cnt=3, wait_max=9.
- m_reqs[4] pulsed 4 clocks and dropped without grant, then a grant with wait 1; sel=4: wait_max=1, grant_cnt=1.
- 300 grant edges on master 5: grant_cnt=255 (saturated). Pulse clr in the same cycle as grant edge 301: grant_cnt=0 next-but-one cycle and stays 0.
- m_grants=12'b0000_0011_1000 for one cycle: grant_conflict=1 and sticky; masters 3, 4, 5 each count +1; clr -> grant_conflict=0.
